// File: rtl/exibe_sequencia_controle.sv
// Show-sequence sequencer for the memory game.
// Walks jogadas memory 0..rodada, lighting each value T_ON then blanking T_OFF.
module exibe_sequencia_controle #(
  parameter int ADDR_W = 4,
  parameter int T_ON   = 3,
  parameter int T_OFF  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              cancela,
  input  logic [ADDR_W-1:0] rodada,
  input  logic [3:0]        dado_mem,
  output logic [ADDR_W-1:0] endereco,
  output logic [3:0]        leds,
  output logic              ocupado,
  output logic              pronto,
  output logic [2:0]        db_estado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  localparam logic [15:0] T_ON_M1  = 16'(T_ON - 1);
  localparam logic [15:0] T_OFF_M1 = 16'(T_OFF - 1);

  estado_t           estado;
  logic [15:0]       timer;
  logic [ADDR_W-1:0] rodada_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= OCIOSO;
      timer      <= '0;
      rodada_reg <= '0;
      endereco   <= '0;
      leds       <= '0;
    end else if (cancela) begin
      // abort wins over start and over timer expiry
      estado   <= OCIOSO;
      timer    <= '0;
      endereco <= '0;
      leds     <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          endereco <= '0;
          leds     <= '0;
          timer    <= '0;
          if (iniciar) begin
            rodada_reg <= rodada;
            estado     <= CARREGA;
          end
        end
        CARREGA: begin
          leds   <= dado_mem;
          timer  <= '0;
          estado <= ACESO;
        end
        ACESO: begin
          if (timer == T_ON_M1) begin
            leds   <= '0;
            timer  <= '0;
            estado <= APAGADO;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        APAGADO: begin
          if (timer == T_OFF_M1) begin
            timer  <= '0;
            estado <= (endereco == rodada_reg) ? FIM : PROXIMO;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        PROXIMO: begin
          endereco <= endereco + 1'b1;
          estado   <= CARREGA;
        end
        FIM: begin
          endereco <= '0;
          estado   <= OCIOSO;
        end
        default: begin
          endereco <= '0;
          leds     <= '0;
          timer    <= '0;
          estado   <= OCIOSO;
        end
      endcase
    end
  end

  assign ocupado   = (estado == CARREGA) || (estado == ACESO) ||
                     (estado == APAGADO) || (estado == PROXIMO);
  assign pronto    = (estado == FIM);
  assign db_estado = estado;

endmodule

// File: tb/tb_exibe_sequencia_controle.sv
// Directed bench for exibe_sequencia_controle (T_ON=3, T_OFF=2).
// Checks per-cycle LEDs, address, state code, ocupado and pronto.
module tb_exibe_sequencia_controle;

  logic       clock = 0;
  logic       reset;
  logic       iniciar;
  logic       cancela;
  logic [3:0] rodada;
  logic [3:0] dado_mem;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [2:0] db_estado;

  logic [3:0] mem [16];

  int n_chk  = 0;
  int n_pass = 0;

  exibe_sequencia_controle #(
    .ADDR_W(4), .T_ON(3), .T_OFF(2)
  ) dut (
    .clock(clock), .reset(reset),
    .iniciar(iniciar), .cancela(cancela),
    .rodada(rodada), .dado_mem(dado_mem),
    .endereco(endereco), .leds(leds),
    .ocupado(ocupado), .pronto(pronto),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  assign dado_mem = mem[endereco];

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".st"},  16'(db_estado), 16'd0);
    chk({tag, ".led"}, 16'(leds),      16'd0);
    chk({tag, ".adr"}, 16'(endereco),  16'd0);
    chk({tag, ".ocp"}, 16'(ocupado),   16'd0);
    chk({tag, ".prt"}, 16'(pronto),    16'd0);
  endtask

  // Start a run and check every cycle up to FIM (cycle 7n) plus one idle cycle.
  // Each value takes 7 cycles: CARREGA, 3 lit, 2 dark, PROXIMO/FIM.
  task automatic run_seq(input string tag, input int n,
                         input logic [3:0] rod, input bit disturb);
    int k, r, p;
    logic [3:0] e_led;
    logic [2:0] e_st;
    p = 7 * n;
    rodada  = rod;
    iniciar = 1;
    tick();
    iniciar = 0;
    for (int c = 1; c <= p; c++) begin
      k = (c - 1) / 7;
      r = (c - 1) % 7;
      e_led = (r >= 1 && r <= 3) ? mem[k] : 4'd0;
      if (r == 0)      e_st = 3'd1;
      else if (r <= 3) e_st = 3'd2;
      else if (r <= 5) e_st = 3'd3;
      else             e_st = (c == p) ? 3'd5 : 3'd4;
      chk($sformatf("%s.c%0d.led", tag, c), 16'(leds), 16'(e_led));
      chk($sformatf("%s.c%0d.adr", tag, c), 16'(endereco), 16'(k));
      chk($sformatf("%s.c%0d.st", tag, c), 16'(db_estado), 16'(e_st));
      chk($sformatf("%s.c%0d.prt", tag, c), 16'(pronto), 16'(c == p));
      chk($sformatf("%s.c%0d.ocp", tag, c), 16'(ocupado), 16'(c != p));
      if (disturb && c == 3) begin
        iniciar = 1;
        rodada  = 4'd3;
      end
      if (disturb && c == 4) iniciar = 0;
      tick();
    end
    chk_idle({tag, ".end"});
  endtask

  initial begin
    reset   = 0;
    iniciar = 0;
    cancela = 0;
    rodada  = 0;
    foreach (mem[i]) mem[i] = 4'(i);

    // 1: reset with random inputs
    iniciar = 1'($urandom);
    rodada  = 4'($urandom);
    #2 reset = 1;
    #1 chk_idle("rst");
    iniciar = 0;
    tick();
    tick();
    chk_idle("rst_hold");
    reset = 0;
    tick();

    // 2: single value
    mem[0] = 4'b0010;
    run_seq("one", 1, 4'd0, 0);

    // 3: three values
    mem[0] = 4'b0001;
    mem[1] = 4'b0010;
    mem[2] = 4'b0100;
    run_seq("three", 3, 4'd2, 0);

    // 4: cancel during ACESO of address 1 (cycle 9)
    rodada  = 4'd2;
    iniciar = 1;
    tick();
    iniciar = 0;
    repeat (8) tick();
    chk("can.pre.st",  16'(db_estado), 16'd2);
    chk("can.pre.adr", 16'(endereco),  16'd1);
    chk("can.pre.led", 16'(leds),      16'b0010);
    cancela = 1;
    tick();
    cancela = 0;
    chk_idle("can.post");
    for (int i = 0; i < 25; i++) begin
      chk($sformatf("can.q%0d.prt", i), 16'(pronto), 16'd0);
      tick();
    end

    // 5: re-pulse iniciar and change rodada mid-run; rodada=1 keeps 2 values
    mem[0] = 4'b1000;
    mem[1] = 4'b0100;
    mem[2] = 4'b0010;
    mem[3] = 4'b0001;
    run_seq("rst_rod", 2, 4'd1, 1);
    iniciar = 1;
    cancela = 1;
    tick();
    chk_idle("ini_can.a");
    iniciar = 0;
    cancela = 0;
    tick();
    chk_idle("ini_can.b");

    // 6: async reset mid-APAGADO of address 1 (cycle 12)
    rodada  = 4'd3;
    iniciar = 1;
    tick();
    iniciar = 0;
    repeat (11) tick();
    chk("ar.pre.st",  16'(db_estado), 16'd3);
    chk("ar.pre.adr", 16'(endereco),  16'd1);
    #2 reset = 1;
    #1 chk_idle("ar.now");
    tick();
    reset = 0;
    chk_idle("ar.held");
    tick();
    run_seq("replay", 2, 4'd1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
